// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and width helpers for the UART transmit arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DBIT      = 8;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 64;

    // Widths for the default configuration: owner index and burst counter.
    localparam int ID_W = $clog2(DEF_NUM_REQ);
    localparam int BC_W = $clog2(DEF_MAX_BURST + 1);

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority picker
//
// Searches req starting one above last_grant, wrapping modulo N, and returns
// the first set bit.
// Ports:
//   req        in   N   request vector
//   last_grant in   W   index of the most recent winner
//   found      out  1   any request set
//   pick       out  W   index of the winning request
module uart_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         found,
    output logic [W-1:0] pick
);

    int          idx;
    logic [W-1:0] idx_w;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_w = '0;
        for (int i = 0; i < N; i++) begin
            idx   = (int'(last_grant) + 1 + i) % N;
            idx_w = idx[W-1:0];
            if (!found && req[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-atomic round-robin arbiter for the UART transmit FIFO write port
//
// Optional feature macro: UART_ARB_TIMEOUT_EN (releases a grant whose owner
// holds valid low for TIMEOUT non-stalled cycles).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_last [N]   per-requester byte valid and end-of-packet
//   req_data [N*DBIT]        packed bytes, requester i at [i*DBIT +: DBIT]
//   req_ready [N]            per-requester accept strobe
//   tx_full                  transmit FIFO full
//   wr_uart, w_data          FIFO write strobe and byte
//   grant_id, busy           current/most recent owner, grant held
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DBIT      = DEF_DBIT,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DBIT-1:0]   req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_full,
    output logic                      wr_uart,
    output logic [DBIT-1:0]           w_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] bc_q, bc_d;
    logic             found;
    logic [OWN_W-1:0] pick;
    logic             xfer;
    logic             rel;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int IC_W = $clog2(TIMEOUT + 1);
    logic [IC_W-1:0]  ic_q, ic_d;
`endif

    uart_rr_pick #(
        .N (NUM_REQ),
        .W (OWN_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .found      (found),
        .pick       (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(NUM_REQ - 1);
            bc_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            ic_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bc_q    <= bc_d;
`ifdef UART_ARB_TIMEOUT_EN
            ic_q    <= ic_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        bc_d      = bc_q;
        req_ready = '0;
        wr_uart   = 1'b0;
        w_data    = '0;
        xfer      = 1'b0;
        rel       = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        ic_d      = ic_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                ic_d = '0;
`endif
                if (found) begin
                    owner_d = pick;
                    bc_d    = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Ready and write are combinational so a full FIFO blocks the
                // byte in the very cycle it is seen.
                req_ready[owner_q] = ~tx_full;
                xfer = req_valid[owner_q] & ~tx_full;
                if (xfer) begin
                    wr_uart = 1'b1;
                    w_data  = req_data[int'(owner_q)*DBIT +: DBIT];
                    bc_d    = bc_q + 1'b1;
                    if (req_last[owner_q] || bc_q == CNT_W'(MAX_BURST - 1))
                        rel = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Only cycles where the owner itself is silent count; FIFO
                // backpressure is not the owner's fault.
                if (xfer) begin
                    ic_d = '0;
                end else if (!req_valid[owner_q] && !tx_full) begin
                    ic_d = ic_q + 1'b1;
                    if (ic_q == IC_W'(TIMEOUT - 1))
                        rel = 1'b1;
                end
`endif
                if (rel) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int MB = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_full;
    logic          wr_uart;
    logic [DB-1:0] w_data;
    logic [1:0]    grant_id;
    logic          busy;

    uart_tx_arb #(
        .NUM_REQ   (N),
        .DBIT      (DB),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] pq [N][$];
    bit         pl [N][$];
    int         hold_from [N];
    int         full_lo, full_hi;
    int         cyc;

    logic [7:0] obs_data [$];
    int         obs_id   [$];
    int         obs_cyc  [$];
    bit         busy_log [$];
    logic [3:0] rdy_log  [$];
    int         gid_log  [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            pl[i].delete();
            hold_from[i] = 1 << 30;
        end
        full_lo = -1;
        full_hi = -2;
        obs_data.delete(); obs_id.delete(); obs_cyc.delete();
        busy_log.delete(); rdy_log.delete(); gid_log.delete();
    endtask

    task automatic load(input int r, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            pq[r].push_back(8'(base + k));
            pl[r].push_back(k == n - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        clear_all();
    endtask

    // One clock of requester behaviour: present queue heads, observe, pop on accept.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() != 0 && cyc < hold_from[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DB +: DB] = pq[i][0];
                req_last[i] = pl[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DB +: DB] = '0;
                req_last[i] = 1'b0;
            end
        end
        tx_full = (cyc >= full_lo && cyc <= full_hi);
        #1;
        busy_log.push_back(busy);
        rdy_log.push_back(req_ready);
        gid_log.push_back(int'(grant_id));
        if (wr_uart) begin
            obs_data.push_back(w_data);
            obs_id.push_back(int'(grant_id));
            obs_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) begin
                void'(pq[i].pop_front());
                void'(pl[i].pop_front());
            end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1; req_data = '1; req_last = '0; tx_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr_uart: got %b want 0", wr_uart); end
        n_checks++; if (w_data !== 8'h00) begin n_fail++; $display("FAIL reset_w_data: got %h want 00", w_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        do_reset();
        load(1, 'hA1, 3);
        repeat (6) cycle();
        n_checks++; if (obs_data.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d want 3", obs_data.size()); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== 8'(8'hA1 + k) || obs_cyc[k] !== k + 1 || obs_id[k] !== 1) begin
                n_fail++;
                $display("FAIL single_byte%0d: got data %h cyc %0d id %0d want data %h cyc %0d id 1", k,
                         (k < obs_data.size()) ? obs_data[k] : 8'h00, (k < obs_cyc.size()) ? obs_cyc[k] : -1,
                         (k < obs_id.size()) ? obs_id[k] : -1, 8'(8'hA1 + k), k + 1);
            end
        end
        n_checks++; if (busy_log[0] !== 1'b0) begin n_fail++; $display("FAIL single_busy_c0: got %b want 0", busy_log[0]); end
        n_checks++; if (busy_log[3] !== 1'b1) begin n_fail++; $display("FAIL single_busy_c3: got %b want 1", busy_log[3]); end
        n_checks++; if (busy_log[4] !== 1'b0) begin n_fail++; $display("FAIL single_busy_c4: got %b want 0", busy_log[4]); end
        n_checks++; if (gid_log[5] !== 1) begin n_fail++; $display("FAIL single_gid_hold: got %0d want 1", gid_log[5]); end
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        do_reset();
        load(0, 'h10, 1); load(1, 'h11, 1); load(2, 'h12, 1); load(3, 'h13, 1); load(0, 'h14, 1);
        repeat (12) cycle();
        n_checks++; if (obs_data.size() !== 5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", obs_data.size()); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== 8'(8'h10 + k) || obs_id[k] !== exp_id[k] || obs_cyc[k] !== 2*k + 1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got data %h id %0d cyc %0d want data %h id %0d cyc %0d", k,
                         (k < obs_data.size()) ? obs_data[k] : 8'h00, (k < obs_id.size()) ? obs_id[k] : -1,
                         (k < obs_cyc.size()) ? obs_cyc[k] : -1, 8'(8'h10 + k), exp_id[k], 2*k + 1);
            end
        end
        n_checks++; if (busy_log[2] !== 1'b0) begin n_fail++; $display("FAIL rr_dead_cycle: got busy %b want 0", busy_log[2]); end
    endtask

    task automatic test_burst();
        int ed, ei, ec;
        do_reset();
        load(2, 'h20, 20);
        load(3, 'h40, 3);
        repeat (30) cycle();
        n_checks++; if (obs_data.size() !== 23) begin n_fail++; $display("FAIL burst_count: got %0d want 23", obs_data.size()); end
        for (int k = 0; k < 23; k++) begin
            if (k < 16)      begin ed = 'h20 + k;        ei = 2; ec = 1 + k; end
            else if (k < 19) begin ed = 'h40 + k - 16;   ei = 3; ec = 18 + k - 16; end
            else             begin ed = 'h30 + k - 19;   ei = 2; ec = 22 + k - 19; end
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== 8'(ed) || obs_id[k] !== ei || obs_cyc[k] !== ec) begin
                n_fail++;
                $display("FAIL burst_byte%0d: got data %h id %0d cyc %0d want data %h id %0d cyc %0d", k,
                         (k < obs_data.size()) ? obs_data[k] : 8'h00, (k < obs_id.size()) ? obs_id[k] : -1,
                         (k < obs_cyc.size()) ? obs_cyc[k] : -1, 8'(ed), ei, ec);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_cyc [6] = '{1, 2, 8, 9, 10, 11};
        do_reset();
        load(0, 'h50, 6);
        full_lo = 3;
        full_hi = 7;
        repeat (14) cycle();
        n_checks++; if (obs_data.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", obs_data.size()); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (k >= obs_data.size() || obs_data[k] !== 8'(8'h50 + k) || obs_cyc[k] !== exp_cyc[k]) begin
                n_fail++;
                $display("FAIL bp_byte%0d: got data %h cyc %0d want data %h cyc %0d", k,
                         (k < obs_data.size()) ? obs_data[k] : 8'h00, (k < obs_cyc.size()) ? obs_cyc[k] : -1,
                         8'(8'h50 + k), exp_cyc[k]);
            end
        end
        for (int c = 3; c <= 7; c++) begin
            n_checks++;
            if (rdy_log[c] !== 4'b0000 || busy_log[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall_c%0d: got ready %b busy %b want ready 0000 busy 1", c, rdy_log[c], busy_log[c]);
            end
        end
        n_checks++; if (rdy_log[2] !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_c2: got %b want 0001", rdy_log[2]); end
        n_checks++; if (rdy_log[8] !== 4'b0001) begin n_fail++; $display("FAIL bp_ready_c8: got %b want 0001", rdy_log[8]); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load(1, 'h60, 4);
        cycle();
        cycle();
        @(negedge clk);
        req_valid = 4'b0010; req_data = '0; req_data[15:8] = 8'h61; req_last = '0; tx_full = 1'b0;
        #1;
        n_checks++;
        if (wr_uart !== 1'b1 || w_data !== 8'h61) begin
            n_fail++; $display("FAIL rstmid_byte2: got wr %b data %h want wr 1 data 61", wr_uart, w_data);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (wr_uart !== 1'b0 || w_data !== 8'h00 || busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got wr %b data %h busy %b gid %0d ready %b want all zero",
                     wr_uart, w_data, busy, grant_id, req_ready);
        end
        @(negedge clk);
        req_valid = '0; req_data = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        clear_all();
        for (int i = 0; i < N; i++) load(i, 'h70 + i, 1);
        repeat (4) cycle();
        n_checks++;
        if (obs_data.size() < 1 || obs_id[0] !== 0 || obs_data[0] !== 8'h70 || obs_cyc[0] !== 1) begin
            n_fail++;
            $display("FAIL rstmid_priority: got id %0d data %h cyc %0d want id 0 data 70 cyc 1",
                     (obs_id.size() > 0) ? obs_id[0] : -1, (obs_data.size() > 0) ? obs_data[0] : 8'h00,
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
        end
    endtask

    task automatic test_stalled_owner();
        do_reset();
        load(0, 'h80, 3);
        load(1, 'h90, 1);
        hold_from[0] = 2;
        repeat (16) cycle();
        n_checks++;
        if (obs_data.size() < 1 || obs_data[0] !== 8'h80 || obs_cyc[0] !== 1) begin
            n_fail++;
            $display("FAIL stall_first: got data %h cyc %0d want data 80 cyc 1",
                     (obs_data.size() > 0) ? obs_data[0] : 8'h00, (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
        end
`ifdef UART_ARB_TIMEOUT_EN
        n_checks++; if (obs_data.size() !== 2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", obs_data.size()); end
        n_checks++; if (busy_log[9] !== 1'b1 || busy_log[10] !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got busy c9 %b c10 %b want 1 0", busy_log[9], busy_log[10]);
        end
        n_checks++;
        if (obs_data.size() < 2 || obs_data[1] !== 8'h90 || obs_id[1] !== 1 || obs_cyc[1] !== 11) begin
            n_fail++;
            $display("FAIL stall_next: got data %h id %0d cyc %0d want data 90 id 1 cyc 11",
                     (obs_data.size() > 1) ? obs_data[1] : 8'h00, (obs_id.size() > 1) ? obs_id[1] : -1,
                     (obs_cyc.size() > 1) ? obs_cyc[1] : -1);
        end
`else
        n_checks++; if (obs_data.size() !== 1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", obs_data.size()); end
        n_checks++; if (busy_log[15] !== 1'b1 || gid_log[15] !== 0) begin
            n_fail++; $display("FAIL stall_hold: got busy %b gid %0d want busy 1 gid 0", busy_log[15], gid_log[15]);
        end
        n_checks++; if (rdy_log[15] !== 4'b0001) begin
            n_fail++; $display("FAIL stall_ready: got %b want 0001", rdy_log[15]);
        end
`endif
    endtask

    initial begin
        cyc = 0;
        clear_all();
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_reset_mid_packet();
        test_stalled_owner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
